// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcode enum, instruction field positions and control struct for control_unit
package control_unit_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ, OP_JMP, OP_MOVI
  } op_e;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 23;
  localparam int RS1_MSB = 22;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 13;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  typedef struct packed {
    logic reg_write;
    logic use_imm;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;
endpackage

// File: rtl/control_unit_opcode_decoder.sv
// opcode_decoder: combinational 4-bit opcode (op) to datapath control struct (ctrl)
module opcode_decoder
  import control_unit_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    ctrl.reg_write = (op >= OP_ADD && op <= OP_LOAD) || op == OP_MOVI;
    ctrl.use_imm   = op >= OP_ADDI && op <= OP_MOVI;
    ctrl.mem_read  = op == OP_LOAD;
    ctrl.mem_write = op == OP_STORE;
    ctrl.branch    = op == OP_BEQ;
    ctrl.jump      = op == OP_JMP;
    ctrl.illegal   = op > OP_MOVI;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: registered decoder; addr (instruction) in, raw fields and datapath enables out one cycle later
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [7:0]  number,
  output logic [3:0]  opcode,
  output logic [4:0]  addr1,
  output logic [4:0]  addr2,
  output logic [4:0]  addr3,
  output logic        reg_write,
  output logic        use_imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);
  ctrl_t ctrl;
  logic  unused_rsvd;
  assign unused_rsvd = ^addr[12:8];
  opcode_decoder u_dec (
    .op  (addr[OPC_MSB:OPC_LSB]),
    .ctrl(ctrl)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      {number, opcode, addr1, addr2, addr3} <= '0;
      {reg_write, use_imm, mem_read, mem_write, branch, jump, illegal} <= '0;
    end else begin
      number <= addr[IMM_MSB:IMM_LSB];
      opcode <= addr[OPC_MSB:OPC_LSB];
      addr1  <= addr[RD_MSB:RD_LSB];
      addr2  <= addr[RS1_MSB:RS1_LSB];
      addr3  <= addr[RS2_MSB:RS2_LSB];
      {reg_write, use_imm, mem_read, mem_write, branch, jump, illegal} <= ctrl;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed plus randomized checks of control_unit against an opcode-table model
module tb_control_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [7:0]  number;
  logic [3:0]  opcode;
  logic [4:0]  addr1, addr2, addr3;
  logic        reg_write, use_imm, mem_read, mem_write, branch, jump, illegal;
  logic [6:0]  en_tab [16];
  logic [33:0] exp_v, obs_v;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  control_unit dut (
    .clk(clk), .rst(rst), .addr(addr), .number(number), .opcode(opcode),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .reg_write(reg_write),
    .use_imm(use_imm), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .illegal(illegal)
  );
  function automatic logic [33:0] model(input logic [31:0] a);
    return {a[7:0], a[31:28], a[27:23], a[22:18], a[17:13], en_tab[a[31:28]]};
  endfunction
  task automatic step(input logic r, input logic [31:0] a);
    rst = r;
    addr = a;
    @(posedge clk);
    #1;
    exp_v = r ? '0 : model(a);
    obs_v = {number, opcode, addr1, addr2, addr3,
             reg_write, use_imm, mem_read, mem_write, branch, jump, illegal};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL decode in=%h rst=%b obs=%h exp=%h", a, r, obs_v, exp_v);
    end
    checks++;
    assert ($countones({mem_read, mem_write, branch, jump}) <= 1 && !(reg_write && illegal)) else begin
      errors++;
      $error("FAIL exclusive obs=%b%b%b%b rw=%b ill=%b exp=one-hot-or-zero, no rw with ill",
             mem_read, mem_write, branch, jump, reg_write, illegal);
    end
  endtask
  initial begin
    en_tab[0] = 7'b0000000;
    for (int i = 1; i <= 5; i++) en_tab[i] = 7'b1000000;
    en_tab[6]  = 7'b1100000;
    en_tab[7]  = 7'b1110000;
    en_tab[8]  = 7'b0101000;
    en_tab[9]  = 7'b0100100;
    en_tab[10] = 7'b0100010;
    en_tab[11] = 7'b1100000;
    for (int i = 12; i <= 15; i++) en_tab[i] = 7'b0000001;
    step(1'b1, 32'h1194E000);
    step(1'b1, 32'h1194E000);
    step(1'b0, 32'h1194E000);
    checks++;
    assert (opcode === 4'd1 && addr1 === 5'd3 && addr2 === 5'd5 && addr3 === 5'd7 && number === 8'h00 && reg_write === 1'b1) else begin
      errors++;
      $error("FAIL first_add obs=%0d/%0d/%0d/%0d/%h/%b exp=1/3/5/7/00/1", opcode, addr1, addr2, addr3, number, reg_write);
    end
    step(1'b0, 32'h6F8000A5);
    checks++;
    assert (opcode === 4'd6 && addr1 === 5'd31 && addr2 === 5'd0 && number === 8'hA5 && use_imm === 1'b1 && illegal === 1'b0) else begin
      errors++;
      $error("FAIL addi obs=%0d/%0d/%0d/%h/%b/%b exp=6/31/0/a5/1/0", opcode, addr1, addr2, number, use_imm, illegal);
    end
    step(1'b0, 32'hF0000000);
    step(1'b0, 32'hC0000000);
    step(1'b0, 32'hD0000000);
    step(1'b0, 32'hE0000000);
    step(1'b0, 32'h1194FF00);
    for (int i = 0; i < 16; i++) step(1'b0, {i[3:0], 28'($urandom)});
    for (int i = 0; i < 8; i++) step(i == 3, {4'(i + 6), 28'($urandom)});
    for (int i = 0; i < 300; i++) step($urandom_range(0, 19) == 0, $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
